hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the vector processor: decides stall and flush for the fetch, decode, execute and memory pipeline registers. It covers three cases that forwarding into execute cannot resolve: load-use dependencies, multi-cycle vector operations occupying execute, and taken branches resolved in execute. It sits beside the execute-stage forwarding mux selector and drives the enable/clear inputs of the IF/ID, ID/EX and EX/MEM registers.

## Interface
- N, 4, register ID width (matches the forwarding unit's register ID width)
- CW, 4, width of the vector-operation cycle count
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- RegA_D, RegB_D  in  N  source register IDs of the instruction in decode
- Rd_E  in  N  destination register ID in execute
- regw_E  in  1  execute instruction writes a register
- memtoreg_E  in  1  execute instruction is a load
- branch_E  in  1  branch resolved taken in execute
- vec_start_E  in  1  first execute cycle of a vector operation
- vec_cycles_E  in  CW  total execute cycles the vector op needs (valid with vec_start_E)
- stall_F, stall_D, stall_E  out  1  hold the PC / IF-ID / ID-EX registers
- flush_D, flush_E, flush_M  out  1  clear IF-ID / ID-EX / EX-MEM to a bubble
- busy  out  1  high while a vector op holds execute

## Operation
- FSM states: IDLE, VEC_BUSY. Down-counter cnt is CW bits wide.
- IDLE, checks in priority order:
  - **Branch:** branch_E=1 -> flush_D=1 and flush_E=1. vec_start_E is ignored, no load-use stall is raised, state stays IDLE.
  - **Vector start:** vec_start_E=1 and vec_cycles_E>=2:
    - outputs: stall_F=stall_D=stall_E=1, flush_M=1, busy=1;
    - next cycle: cnt<=vec_cycles_E-2, state<=VEC_BUSY.
    - vec_cycles_E of 0 or 1 is a single-cycle op: no stall, stay IDLE.
  - **Load-use:** regw_E & memtoreg_E & (Rd_E==RegA_D | Rd_E==RegB_D) -> stall_F=stall_D=1 and flush_E=1 for this cycle only. The load moves to memory and the forwarding path resolves the operand next cycle.
- VEC_BUSY:
  - outputs: stall_F=stall_D=stall_E=1, flush_M=1, busy=1; load-use detection is suppressed.
  - cnt!=0 -> cnt<=cnt-1.
  - cnt==0 -> state<=IDLE. This is the op's last execute cycle: all outputs drop to 0 that cycle and the op advances to memory on the next edge.
  - branch_E, vec_start_E and vec_cycles_E are ignored in this state.
- All outputs are combinational from state, cnt and the current inputs. No output depends on an input from a previous cycle except through state and cnt.
- Stall and flush of the same register never assert together.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0. All outputs read 0 from the following cycle until a new hazard is detected.
- Reset mid-VEC_BUSY aborts the operation with no pending stall.
- Load-use: exactly 1 stall cycle, same cycle as detection.
- Branch: flush is active in the same cycle branch_E is high; penalty is 2 bubbles.
- Vector op of C>=2 cycles: stall and busy are high for exactly C-1 consecutive cycles, starting in the vec_start_E cycle. cnt maximum is 2^CW-1; C=2^CW-1 gives 2^CW-2 stall cycles.
- If vec_start_E is high in the final VEC_BUSY cycle, it is ignored. Upstream must not issue that, because execute is still occupied.

## Configuration
- HAZARD_STATS_EN defined:
  - adds output stall_cnt (16 bits), which increments on every cycle with stall_D=1;
  - adds output flush_cnt (16 bits), which increments once per taken-branch flush event;
  - both counters saturate at 16'hFFFF and reset to 0 on rst_n=0.
- HAZARD_STATS_EN undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- **Reset:** rst_n=0 for 2 cycles with branch_E=1 held -> all outputs 0 on the cycle after rst_n rises, until branch_E is re-evaluated.
- **Load-use:** Rd_E=3, memtoreg_E=1, regw_E=1, RegB_D=3 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle. With regw_E=0 instead -> no stall.
- **Vector op:** vec_start_E=1, vec_cycles_E=5 -> stall_F/D/E, flush_M and busy high for 4 consecutive cycles, 0 on the 5th.
- **Single-cycle vector op:** vec_cycles_E=1 -> no stall. vec_cycles_E=15 (CW=4) -> 14 stall cycles.
- **Branch priority:** branch_E=1 together with vec_start_E=1 and a load-use match -> only flush_D and flush_E assert, busy stays 0.
- **Reset mid-op:** rst_n=0 in the 2nd cycle of a vec_cycles_E=8 op -> busy=0 and state IDLE after the reset edge. With HAZARD_STATS_EN defined, stall_cnt=0 after that edge.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle vector-op stalls and taken-branch flushes.
// Optional per-event statistics counters are enabled with the HAZARD_STATS_EN macro.
module hazard_stall_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  RegA_D,
  input  logic [N-1:0]  RegB_D,
  input  logic [N-1:0]  Rd_E,
  input  logic          regw_E,
  input  logic          memtoreg_E,
  input  logic          branch_E,
  input  logic          vec_start_E,
  input  logic [CW-1:0] vec_cycles_E,
  output logic          stall_F,
  output logic          stall_D,
  output logic          stall_E,
  output logic          flush_D,
  output logic          flush_E,
  output logic          flush_M,
  output logic          busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    VEC_BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_use;

  // Decode reads the register a load in execute has not produced yet.
  assign load_use = regw_E & memtoreg_E & ((Rd_E == RegA_D) | (Rd_E == RegB_D));

  // Next state and hazard outputs; the final vector cycle drops everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (branch_E) begin
          flush_D = 1'b1;
          flush_E = 1'b1;
        end else if (vec_start_E && (vec_cycles_E >= CW'(2))) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          flush_M = 1'b1;
          busy    = 1'b1;
          cnt_d   = vec_cycles_E - CW'(2);
          state_d = VEC_BUSY;
        end else if (load_use) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end
      end
      VEC_BUSY: begin
        if (cnt_q != '0) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          flush_M = 1'b1;
          busy    = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        flush_event;

  assign flush_event = (state_q == IDLE) & branch_E;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_D && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_event && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: behavioural occupancy model plus directed literal checks.
module tb_hazard_stall_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  RegA_D, RegB_D, Rd_E;
  logic          regw_E, memtoreg_E, branch_E, vec_start_E;
  logic [CW-1:0] vec_cycles_E;
  logic          stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, busy;
`ifdef HAZARD_STATS_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  hazard_stall_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegA_D(RegA_D), .RegB_D(RegB_D), .Rd_E(Rd_E),
    .regw_E(regw_E), .memtoreg_E(memtoreg_E), .branch_E(branch_E),
    .vec_start_E(vec_start_E), .vec_cycles_E(vec_cycles_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .busy(busy)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: occ = execute cycles the current vector op still owns, counting this one.
  int occ = 0;
  int stall_m = 0;
  int flush_m = 0;
  logic [6:0] obs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [6:0] exp;
    int occ_n, stall_n, flush_n;
    logic lu;
    @(negedge clk);
    obs = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, busy};
    exp = '0;
    occ_n = 0;
    stall_n = stall_m;
    flush_n = flush_m;
    lu = regw_E && memtoreg_E && (Rd_E == RegA_D || Rd_E == RegB_D);
    if (occ >= 2) begin
      exp = 7'b1110011;
      occ_n = occ - 1;
    end else if (occ == 1) begin
      occ_n = 0;
    end else if (branch_E) begin
      exp = 7'b0001100;
      flush_n = (flush_m < 65535) ? flush_m + 1 : flush_m;
    end else if (vec_start_E && int'(vec_cycles_E) >= 2) begin
      exp = 7'b1110011;
      occ_n = int'(vec_cycles_E) - 1;
    end else if (lu) begin
      exp = 7'b1100100;
    end
    if (exp[5]) stall_n = (stall_m < 65535) ? stall_m + 1 : stall_m;
    if (rst_n) begin
      check("outputs", 32'(obs), 32'(exp));
`ifdef HAZARD_STATS_EN
      check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
      check("flush_cnt", 32'(flush_cnt), 32'(flush_m));
`endif
    end else begin
      occ_n = 0;
      stall_n = 0;
      flush_n = 0;
    end
    @(posedge clk);
    occ = occ_n;
    stall_m = stall_n;
    flush_m = flush_n;
    #1;
  endtask

  task automatic clear_inputs();
    RegA_D = '0; RegB_D = '0; Rd_E = '0;
    regw_E = 1'b0; memtoreg_E = 1'b0; branch_E = 1'b0;
    vec_start_E = 1'b0; vec_cycles_E = '0;
  endtask

  // Launch a vector op of c cycles, then count busy cycles over a window.
  task automatic vec_run(input int c, input int window, output int nbusy);
    clear_inputs();
    vec_start_E = 1'b1;
    vec_cycles_E = CW'(c);
    cycle();
    nbusy = int'(obs[0]);
    clear_inputs();
    for (int i = 1; i < window; i++) begin
      cycle();
      nbusy += int'(obs[0]);
    end
  endtask

  initial begin
    int nb;
    clear_inputs();
    rst_n = 1'b0;
    branch_E = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;
    branch_E = 1'b0;
    cycle();
    check("reset_outs", 32'(obs), 32'h0);
`ifdef HAZARD_STATS_EN
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
`endif

    // Load-use on RegB_D.
    Rd_E = 4'd3; memtoreg_E = 1'b1; regw_E = 1'b1; RegB_D = 4'd3; RegA_D = 4'd0;
    cycle();
    check("load_use", 32'(obs), 32'h64);
    clear_inputs();
    cycle();
    check("load_use_one_cycle", 32'(obs), 32'h0);
    Rd_E = 4'd3; memtoreg_E = 1'b1; regw_E = 1'b0; RegB_D = 4'd3;
    cycle();
    check("load_no_regw", 32'(obs), 32'h0);

    vec_run(5, 8, nb);
    check("vec5_busy_cycles", 32'(nb), 32'd4);
    vec_run(1, 3, nb);
    check("vec1_busy_cycles", 32'(nb), 32'd0);
    vec_run(15, 18, nb);
    check("vec15_busy_cycles", 32'(nb), 32'd14);
    vec_run(2, 3, nb);
    check("vec2_busy_cycles", 32'(nb), 32'd1);

    // Branch wins over vector start and load-use.
    clear_inputs();
    branch_E = 1'b1; vec_start_E = 1'b1; vec_cycles_E = 4'd5;
    Rd_E = 4'd2; RegA_D = 4'd2; regw_E = 1'b1; memtoreg_E = 1'b1;
    cycle();
    check("branch_priority", 32'(obs), 32'h0C);
    clear_inputs();
    cycle();
    check("branch_no_busy", 32'(obs), 32'h0);

    // Reset in the 2nd cycle of an 8-cycle op.
    vec_start_E = 1'b1; vec_cycles_E = 4'd8;
    cycle();
    clear_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("reset_midop", 32'(obs), 32'h0);
`ifdef HAZARD_STATS_EN
    check("reset_midop_stall_cnt", 32'(stall_cnt), 32'h0);
`endif

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(199, 0) != 0);
      RegA_D       = N'($urandom_range(3, 0));
      RegB_D       = N'($urandom_range(3, 0));
      Rd_E         = N'($urandom_range(3, 0));
      regw_E       = ($urandom_range(3, 0) != 0);
      memtoreg_E   = ($urandom_range(1, 0) != 0);
      branch_E     = ($urandom_range(9, 0) == 0);
      vec_start_E  = ($urandom_range(9, 0) == 0);
      vec_cycles_E = CW'($urandom_range(15, 0));
      if (vec_start_E && vec_cycles_E < CW'(2)) memtoreg_E = 1'b0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
